// File: rtl/debug_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : debug_bus_master
//  Description : Host-side debug bus master. Assembles 9-byte command frames,
//                runs one bus transaction, returns a 9-byte response frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_bus_master #(
    parameter int          TIMEOUT   = 16,
    parameter logic [7:0]  IDLE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  bus_addr,
    output logic        bus_start,
    inout  wire  [63:0] bus_data,
    input  logic        bus_available,
    input  logic        bus_accepted,
    output logic        busy
);

    localparam int c_WAIT_W = $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [3:0] c_LAST_BYTE = 4'd8;
    localparam logic [7:0] c_STATUS_OK      = 8'h00;
    localparam logic [7:0] c_STATUS_NOT_ACC = 8'h01;
    localparam logic [7:0] c_STATUS_TIMEOUT = 8'h02;

    typedef enum logic [2:0] {
        S_RX         = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_ACC   = 3'd2,
        S_WAIT_AVAIL = 3'd3,
        S_TX         = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_byte_cnt;
    logic [71:0]           r_cmd;
    logic [63:0]           r_resp;
    logic [7:0]            r_status;
    logic [c_WAIT_W-1:0]   r_wait_cnt;

    logic                  w_drive;
    logic [6:0]            w_byte_idx;
    logic [71:0]           w_tx_frame;
    logic                  w_last_byte;
    logic                  w_rx_fire;
    logic                  w_tx_fire;
    logic                  w_acc;
    logic                  w_avail;

    // Slave handshakes float when unaddressed; only a clean 1 counts.
    assign w_acc       = (bus_accepted === 1'b1);
    assign w_avail     = (bus_available === 1'b1);
    assign w_rx_fire   = (r_state == S_RX) && (rx_valid === 1'b1);
    assign w_tx_fire   = (r_state == S_TX) && (tx_ready === 1'b1);
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_byte_idx  = {r_byte_cnt, 3'b000};
    assign w_tx_frame  = {r_resp, r_status};

    assign busy     = (r_state != S_RX);
    assign bus_data = w_drive ? r_cmd[71:8] : 64'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RX;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        bus_start   = 1'b0;
        bus_addr    = IDLE_ADDR;
        w_drive     = 1'b0;
        case (r_state)
            S_RX: begin
                rx_ready = 1'b1;
                if (w_rx_fire && w_last_byte) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus_addr    = r_cmd[7:0];
                bus_start   = 1'b1;
                w_drive     = 1'b1;
                w_state_nxt = S_WAIT_ACC;
            end
            S_WAIT_ACC: begin
                bus_addr    = r_cmd[7:0];
                w_state_nxt = w_acc ? S_WAIT_AVAIL : S_TX;
            end
            S_WAIT_AVAIL: begin
                // Address stays put: the slave only answers while it is selected.
                bus_addr = r_cmd[7:0];
                if (w_avail || (r_wait_cnt == c_WAIT_LAST)) begin
                    w_state_nxt = S_TX;
                end
            end
            S_TX: begin
                tx_valid = 1'b1;
                tx_data  = w_tx_frame[w_byte_idx +: 8];
                if (w_tx_fire && w_last_byte) begin
                    w_state_nxt = S_RX;
                end
            end
            default: begin
                w_state_nxt = S_RX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 4'd0;
            r_cmd      <= 72'd0;
            r_resp     <= 64'd0;
            r_status   <= 8'h00;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_RX: begin
                    if (w_rx_fire) begin
                        r_cmd[w_byte_idx +: 8] <= rx_data;
                        r_byte_cnt <= w_last_byte ? 4'd0 : r_byte_cnt + 4'd1;
                    end
                end
                S_WAIT_ACC: begin
                    r_wait_cnt <= '0;
                    if (!w_acc) begin
                        r_status <= c_STATUS_NOT_ACC;
                        r_resp   <= 64'd0;
                    end
                end
                S_WAIT_AVAIL: begin
                    if (w_avail) begin
                        r_resp   <= bus_data;
                        r_status <= c_STATUS_OK;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_status <= c_STATUS_TIMEOUT;
                        r_resp   <= 64'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_TX: begin
                    if (w_tx_fire) begin
                        r_byte_cnt <= w_last_byte ? 4'd0 : r_byte_cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_debug_bus_master
//  Description : Scoreboard bench for debug_bus_master with a register-file
//                slave at addr 1 and an accept-only stub at addr 9.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_bus_master;

    localparam int         c_TIMEOUT = 16;
    localparam logic [7:0] c_IDLE    = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  bus_addr;
    logic        bus_start;
    wire  [63:0] bus_data;
    logic        bus_available;
    logic        bus_accepted;
    logic        busy;

    always #5 clk = ~clk;

    debug_bus_master #(.TIMEOUT(c_TIMEOUT), .IDLE_ADDR(c_IDLE)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_addr(bus_addr), .bus_start(bus_start), .bus_data(bus_data),
        .bus_available(bus_available), .bus_accepted(bus_accepted),
        .busy(busy)
    );

    // Register-file slave (addr 1): payload bit0=write, [7:1]=reg, [63:32]=value.
    logic [31:0] s_regs [0:127];
    logic        s_acc, s_avail, s_drive, stub_acc;
    logic [63:0] s_rdata;

    assign bus_data      = s_drive ? s_rdata : 64'bz;
    assign bus_accepted  = s_acc | stub_acc;
    assign bus_available = s_avail;

    always @(posedge clk) begin
        if (rst) begin
            s_acc    <= 1'b0;
            s_avail  <= 1'b0;
            s_drive  <= 1'b0;
            stub_acc <= 1'b0;
            s_rdata  <= 64'd0;
        end else begin
            s_acc    <= bus_start && (bus_addr == 8'h01);
            stub_acc <= bus_start && (bus_addr == 8'h09);
            s_avail  <= s_acc;
            s_drive  <= s_acc;
            if (bus_start && (bus_addr == 8'h01)) begin
                if (bus_data[0]) begin
                    s_regs[bus_data[7:1]] <= bus_data[63:32];
                    s_rdata <= 64'd1;
                end else begin
                    s_rdata <= {32'd0, s_regs[bus_data[7:1]]};
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues and the bench's own register model
    logic [7:0]  exp_bytes [$];
    int          exp_lat   [$];
    logic [71:0] exp_issue [$];
    logic [31:0] m_regs    [0:127];

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("rx_wait_bound", 72'(n), 72'(0));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [63:0] pl, input bit expect_resp);
        logic [7:0]  st;
        logic [63:0] rsp;
        int          lat;
        exp_issue.push_back({pl, addr});
        if (expect_resp) begin
            if (addr == 8'h01) begin
                st  = 8'h00;
                lat = 3;
                if (pl[0]) begin
                    m_regs[pl[7:1]] = pl[63:32];
                    rsp = 64'd1;
                end else begin
                    rsp = {32'd0, m_regs[pl[7:1]]};
                end
            end else if (addr == 8'h09) begin
                st  = 8'h02;
                rsp = 64'd0;
                lat = 2 + c_TIMEOUT;
            end else begin
                st  = 8'h01;
                rsp = 64'd0;
                lat = 2;
            end
            exp_bytes.push_back(st);
            for (int i = 0; i < 8; i++) exp_bytes.push_back(rsp[i*8 +: 8]);
            exp_lat.push_back(lat);
        end
        send_byte(addr);
        for (int i = 0; i < 8; i++) send_byte(pl[i*8 +: 8]);
    endtask

    task automatic pulse_reset_and_check(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_rx_ready"}, 72'(rx_ready), 72'(1));
        check_eq({tag, "_tx_valid"}, 72'(tx_valid), 72'(0));
        check_eq({tag, "_tx_data"},  72'(tx_data),  72'(0));
        check_eq({tag, "_bus_addr"}, 72'(bus_addr), 72'(c_IDLE));
        check_eq({tag, "_bus_start"}, 72'(bus_start), 72'(0));
        check_eq({tag, "_busy"},     72'(busy),     72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // tx_ready driver: steady 1, or the repeating 1-0-0-1 stall pattern
    bit         bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;
    initial begin
        int k;
        k = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                tx_ready = bp_pat[k % 4];
                k++;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Output monitor: issue contents, single-cycle start, latency, tx bytes, stall stability
    initial begin
        int          cyc, issue_cyc, byte_idx, e_lat;
        bit          lat_done, stalled, prev_start;
        logic [7:0]  held, e_byte;
        logic [71:0] e_issue;
        cyc = 0; issue_cyc = 0; byte_idx = 0;
        lat_done = 0; stalled = 0; prev_start = 0; held = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                byte_idx = 0; lat_done = 0; stalled = 0; prev_start = 0;
            end else begin
                if (bus_start) begin
                    check_eq("start_one_cycle", 72'(prev_start), 72'(0));
                    if (exp_issue.size() == 0) begin
                        check_eq("unexpected_issue", 72'(1), 72'(0));
                    end else begin
                        e_issue = exp_issue.pop_front();
                        check_eq("issue_addr", 72'(bus_addr), 72'(e_issue[7:0]));
                        check_eq("issue_data", 72'(bus_data), 72'(e_issue[71:8]));
                    end
                    issue_cyc = cyc;
                end
                prev_start = bus_start;
                if (tx_valid) begin
                    if (stalled) check_eq("tx_stable_stall", 72'(tx_data), 72'(held));
                    if (byte_idx == 0 && !lat_done) begin
                        lat_done = 1;
                        if (exp_lat.size() == 0) begin
                            check_eq("unexpected_frame", 72'(1), 72'(0));
                        end else begin
                            e_lat = exp_lat.pop_front();
                            check_eq("first_tx_latency", 72'(cyc - issue_cyc), 72'(e_lat));
                        end
                    end
                    if (tx_ready) begin
                        if (exp_bytes.size() == 0) begin
                            check_eq("unexpected_tx", 72'(1), 72'(0));
                        end else begin
                            e_byte = exp_bytes.pop_front();
                            check_eq("tx_byte", 72'(tx_data), 72'(e_byte));
                        end
                        byte_idx = (byte_idx + 1) % 9;
                        if (byte_idx == 0) lat_done = 0;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        held    = tx_data;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rx_ready",  72'(rx_ready),  72'(1));
        check_eq("reset_tx_valid",  72'(tx_valid),  72'(0));
        check_eq("reset_tx_data",   72'(tx_data),   72'(0));
        check_eq("reset_bus_addr",  72'(bus_addr),  72'(c_IDLE));
        check_eq("reset_bus_start", 72'(bus_start), 72'(0));
        check_eq("reset_busy",      72'(busy),      72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write reg1 = DEADBEEF, read it back, then unmapped and timed-out targets
        send_frame(8'h01, 64'hDEADBEEF_00000003, 1'b1);
        send_frame(8'h01, 64'h00000000_00000002, 1'b1);
        send_frame(8'h07, 64'h11223344_55667788, 1'b1);
        send_frame(8'h09, 64'h00000000_00000002, 1'b1);

        // Stalled response with a command byte held valid throughout busy
        bp_mode = 1'b1;
        send_frame(8'h01, 64'h00000000_00000002, 1'b1);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rx_ready_while_busy", 72'(rx_ready), 72'(0));
            check_eq("busy_while_busy",     72'(busy),     72'(1));
        end
        send_frame(8'h01, 64'h00000000_00000002, 1'b1);
        n = 0;
        while (exp_bytes.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        bp_mode = 1'b0;

        // Reset while waiting on the stub, then after a partial frame
        send_frame(8'h09, 64'h0, 1'b0);
        repeat (6) @(posedge clk);
        pulse_reset_and_check("rst_wait_avail");
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        pulse_reset_and_check("rst_partial_rx");
        send_frame(8'h01, 64'h00000000_00000002, 1'b1);
        send_frame(8'h01, 64'hCAFEF00D_0000000B, 1'b1);
        send_frame(8'h01, 64'h00000000_0000000A, 1'b1);

        n = 0;
        while ((exp_bytes.size() != 0 || exp_lat.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_tx_bytes", 72'(exp_bytes.size()), 72'(0));
        check_eq("drain_frames",   72'(exp_lat.size()),   72'(0));
        repeat (20) @(negedge clk);
        check_eq("idle_after_drain", 72'(busy), 72'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
